// File: rtl/btb_ctrl.sv
// 2-way set-associative branch target buffer: lookup, update handshake, LRU and sequenced flush.
// Optional BTB_STATS_EN adds saturating lookup/hit counters; otherwise the stat ports read 0.
module btb_ctrl #(
   parameter int ADDR_WIDTH   = 32,
   parameter int BRANCH_PC    = 10,
   parameter int OFFSET_WIDTH = 4,
   parameter int INDEX_WIDTH  = 3,
   parameter int TAG_WIDTH    = BRANCH_PC - (OFFSET_WIDTH + INDEX_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  lookup_valid,
   input  logic [BRANCH_PC-1:0]  lookup_pc,
   output logic                  lookup_hit,
   output logic [ADDR_WIDTH-1:0] lookup_target,
   input  logic                  upd_valid,
   output logic                  upd_ready,
   input  logic [BRANCH_PC-1:0]  upd_pc,
   input  logic [ADDR_WIDTH-1:0] upd_target,
   input  logic                  upd_taken,
   input  logic                  flush_req,
   output logic                  flush_busy,
   output logic [31:0]           stat_lookups,
   output logic [31:0]           stat_hits
);

   // state  | meaning
   // IDLE   | serving lookups and accepting updates
   // FLUSH  | clearing one set per cycle, lookups return miss
   localparam int SETS = 1 << INDEX_WIDTH;
   localparam int IDX_LO = OFFSET_WIDTH;
   localparam int TAG_LO = OFFSET_WIDTH + INDEX_WIDTH;
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   logic [0:0]             state;
   logic [INDEX_WIDTH-1:0] flush_cnt;
   logic [1:0]             valid_q  [SETS];
   logic [TAG_WIDTH-1:0]   tag_q    [SETS][2];
   logic [ADDR_WIDTH-1:0]  target_q [SETS][2];
   logic [SETS-1:0]        lru_q;

   logic                   idle;
   logic [INDEX_WIDTH-1:0] lk_idx, up_idx;
   logic [TAG_WIDTH-1:0]   lk_tag, up_tag;
   logic                   lk_hit0, lk_hit1, lk_hit, lk_way, lk_fire;
   logic [ADDR_WIDTH-1:0]  lk_target;
   logic                   up_hit0, up_hit1, up_hit, up_way, up_fire, victim;
   logic                   unused_pc_bits;

   assign unused_pc_bits = ^{lookup_pc[OFFSET_WIDTH-1:0], upd_pc[OFFSET_WIDTH-1:0]};

   assign idle       = (state == ST_IDLE);
   assign flush_busy = (state == ST_FLUSH);
   assign upd_ready  = idle && !flush_req;

   assign lk_idx    = lookup_pc[TAG_LO-1:IDX_LO];
   assign lk_tag    = lookup_pc[BRANCH_PC-1:TAG_LO];
   assign lk_hit0   = valid_q[lk_idx][0] && (tag_q[lk_idx][0] == lk_tag);
   assign lk_hit1   = valid_q[lk_idx][1] && (tag_q[lk_idx][1] == lk_tag);
   assign lk_hit    = lk_hit0 || lk_hit1;
   assign lk_way    = !lk_hit0;
   assign lk_target = target_q[lk_idx][lk_way];
   assign lk_fire   = lookup_valid && idle;

   assign up_idx  = upd_pc[TAG_LO-1:IDX_LO];
   assign up_tag  = upd_pc[BRANCH_PC-1:TAG_LO];
   assign up_hit0 = valid_q[up_idx][0] && (tag_q[up_idx][0] == up_tag);
   assign up_hit1 = valid_q[up_idx][1] && (tag_q[up_idx][1] == up_tag);
   assign up_hit  = up_hit0 || up_hit1;
   assign up_way  = !up_hit0;
   assign up_fire = upd_valid && upd_ready;

   always_comb begin
      victim = lru_q[up_idx];
      if (!valid_q[up_idx][0])
         victim = 1'b0;
      else if (!valid_q[up_idx][1])
         victim = 1'b1;
   end

   // Update LRU assignments come after the lookup's so a same-set update wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         flush_cnt     <= '0;
         lru_q         <= '0;
         lookup_hit    <= 1'b0;
         lookup_target <= '0;
         for (int s = 0; s < SETS; s++)
            valid_q[s] <= 2'b00;
      end else begin
         case (state)
            ST_IDLE: begin
               if (flush_req) begin
                  state     <= ST_FLUSH;
                  flush_cnt <= '0;
               end
            end
            ST_FLUSH: begin
               valid_q[flush_cnt] <= 2'b00;
               lru_q[flush_cnt]   <= 1'b0;
               flush_cnt          <= flush_cnt + INDEX_WIDTH'(1);
               if (flush_cnt == INDEX_WIDTH'(SETS - 1))
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         if (lk_fire) begin
            lookup_hit    <= lk_hit;
            lookup_target <= lk_hit ? lk_target : '0;
            if (lk_hit)
               lru_q[lk_idx] <= ~lk_way;
         end else begin
            lookup_hit <= 1'b0;
            if (lookup_valid)
               lookup_target <= '0;
         end

         if (up_fire) begin
            if (upd_taken) begin
               if (up_hit) begin
                  lru_q[up_idx] <= ~up_way;
               end else begin
                  valid_q[up_idx][victim] <= 1'b1;
                  lru_q[up_idx]           <= ~victim;
               end
            end else if (up_hit) begin
               valid_q[up_idx][up_way] <= 1'b0;
               lru_q[up_idx]           <= up_way;
            end
         end
      end
   end

   // Tag/target payload needs no reset: it is only observed through valid bits.
   always_ff @(posedge clk) begin
      if (up_fire && upd_taken) begin
         if (up_hit) begin
            target_q[up_idx][up_way] <= upd_target;
         end else begin
            tag_q[up_idx][victim]    <= up_tag;
            target_q[up_idx][victim] <= upd_target;
         end
      end
   end

`ifdef BTB_STATS_EN
   logic [31:0] lookups_q, hits_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lookups_q <= '0;
         hits_q    <= '0;
      end else if (idle && flush_req) begin
         lookups_q <= '0;
         hits_q    <= '0;
      end else if (lk_fire) begin
         if (lookups_q != 32'hFFFF_FFFF)
            lookups_q <= lookups_q + 32'd1;
         if (lk_hit && hits_q != 32'hFFFF_FFFF)
            hits_q <= hits_q + 32'd1;
      end
   end

   assign stat_lookups = lookups_q;
   assign stat_hits    = hits_q;
`else
   assign stat_lookups = '0;
   assign stat_hits    = '0;
`endif

endmodule

// File: tb/tb_btb_ctrl.sv
// Directed self-checking bench for btb_ctrl: lookup/update, LRU, not-taken, flush, reset, stats.
module tb_btb_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        lookup_valid;
   logic [9:0]  lookup_pc;
   logic        lookup_hit;
   logic [31:0] lookup_target;
   logic        upd_valid;
   logic        upd_ready;
   logic [9:0]  upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic        flush_req;
   logic        flush_busy;
   logic [31:0] stat_lookups;
   logic [31:0] stat_hits;

   int checks = 0;
   int failures = 0;

   btb_ctrl dut (
      .clk(clk), .rst(rst),
      .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .lookup_hit(lookup_hit), .lookup_target(lookup_target),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
      .upd_target(upd_target), .upd_taken(upd_taken),
      .flush_req(flush_req), .flush_busy(flush_busy),
      .stat_lookups(stat_lookups), .stat_hits(stat_hits)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_lookup(input logic [9:0] pc);
      lookup_pc    = pc;
      lookup_valid = 1'b1;
      tick();
      lookup_valid = 1'b0;
   endtask

   task automatic do_update(input logic [9:0] pc, input logic [31:0] tgt, input logic taken);
      upd_pc     = pc;
      upd_target = tgt;
      upd_taken  = taken;
      upd_valid  = 1'b1;
      for (int i = 0; i < 20 && !upd_ready; i++) tick();
      tick();
      upd_valid = 1'b0;
   endtask

   task automatic do_flush();
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      for (int i = 0; i < 20 && flush_busy; i++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; lookup_valid = 0; lookup_pc = 0; upd_valid = 0; upd_pc = 0;
      upd_target = 0; upd_taken = 0; flush_req = 0;
      tick(); tick();
      checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", lookup_hit); end
      checks++; if (lookup_target !== 32'h0) begin failures++; $display("FAIL reset_target got=%h exp=0", lookup_target); end
      checks++; if (flush_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", flush_busy); end
      checks++; if (stat_lookups !== 32'h0 || stat_hits !== 32'h0) begin failures++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_lookups, stat_hits); end
      rst = 1'b0;
      tick();
      checks++; if (upd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", upd_ready); end
      do_lookup(10'h0A4);
      checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL reset_lookup_miss got=%b exp=0", lookup_hit); end
   endtask

   task automatic test_taken();
      do_update(10'h0A4, 32'h0000_1000, 1'b1);
      do_lookup(10'h0A4);
      checks++; if (lookup_hit !== 1'b1) begin failures++; $display("FAIL taken_hit got=%b exp=1", lookup_hit); end
      checks++; if (lookup_target !== 32'h0000_1000) begin failures++; $display("FAIL taken_target got=%h exp=00001000", lookup_target); end
   endtask

   task automatic test_lru();
      do_update(10'h0A4, 32'h0000_1000, 1'b1);
      do_update(10'h1A4, 32'h0000_2000, 1'b1);
      do_lookup(10'h0A4);
      checks++; if (lookup_hit !== 1'b1) begin failures++; $display("FAIL lru_pre_hit got=%b exp=1", lookup_hit); end
      do_update(10'h2A4, 32'h0000_3000, 1'b1);
      do_lookup(10'h1A4);
      checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL lru_evicted got=%b exp=0", lookup_hit); end
      do_lookup(10'h0A4);
      checks++; if (lookup_hit !== 1'b1 || lookup_target !== 32'h0000_1000) begin failures++; $display("FAIL lru_keep got=%b/%h exp=1/00001000", lookup_hit, lookup_target); end
      do_lookup(10'h2A4);
      checks++; if (lookup_hit !== 1'b1 || lookup_target !== 32'h0000_3000) begin failures++; $display("FAIL lru_new got=%b/%h exp=1/00003000", lookup_hit, lookup_target); end
   endtask

   task automatic test_not_taken();
      do_update(10'h0A4, 32'h0, 1'b0);
      do_lookup(10'h0A4);
      checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL nt_invalidate got=%b exp=0", lookup_hit); end
      do_update(10'h3A4, 32'h0, 1'b0);
      do_lookup(10'h2A4);
      checks++; if (lookup_hit !== 1'b1 || lookup_target !== 32'h0000_3000) begin failures++; $display("FAIL nt_absent got=%b/%h exp=1/00003000", lookup_hit, lookup_target); end
      do_lookup(10'h3A4);
      checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL nt_absent_miss got=%b exp=0", lookup_hit); end
   endtask

   task automatic test_back_to_back();
      lookup_pc = 10'h1A4; lookup_valid = 1'b1;
      upd_pc = 10'h1A4; upd_target = 32'h0000_4000; upd_taken = 1'b1; upd_valid = 1'b1;
      tick();
      lookup_valid = 1'b0; upd_valid = 1'b0;
      checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL rbw_old got=%b exp=0", lookup_hit); end
      do_lookup(10'h1A4);
      checks++; if (lookup_hit !== 1'b1 || lookup_target !== 32'h0000_4000) begin failures++; $display("FAIL rbw_new got=%b/%h exp=1/00004000", lookup_hit, lookup_target); end
      tick();
      checks++; if (lookup_hit !== 1'b0 || lookup_target !== 32'h0000_4000) begin failures++; $display("FAIL idle_hold got=%b/%h exp=0/00004000", lookup_hit, lookup_target); end
   endtask

   task automatic test_flush();
      int n;
      for (int i = 0; i < 8; i++) begin
         logic [9:0] pc;
         pc = 10'h200 | 10'(i << 4);
         do_update(pc, 32'h5000 + 32'(i), 1'b1);
      end
      for (int i = 0; i < 8; i++) begin
         logic [9:0] pc;
         pc = 10'h200 | 10'(i << 4);
         do_lookup(pc);
         checks++; if (lookup_hit !== 1'b1 || lookup_target !== 32'h5000 + 32'(i)) begin failures++; $display("FAIL pop_set%0d got=%b/%h exp=1/%h", i, lookup_hit, lookup_target, 32'h5000 + 32'(i)); end
      end
      flush_req = 1'b1; upd_valid = 1'b1; upd_pc = 10'h300; upd_target = 32'h0000_6000; upd_taken = 1'b1;
      #1;
      checks++; if (upd_ready !== 1'b0) begin failures++; $display("FAIL flush_blocks_upd got=%b exp=0", upd_ready); end
      @(posedge clk); #1;
      flush_req = 1'b0; upd_valid = 1'b0;
      lookup_pc = 10'h250; lookup_valid = 1'b1;
      n = 0;
      while (flush_busy && n < 20) begin
         checks++; if (upd_ready !== 1'b0) begin failures++; $display("FAIL flush_ready cyc=%0d got=%b exp=0", n, upd_ready); end
         checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL flush_lookup cyc=%0d got=%b exp=0", n, lookup_hit); end
         n++;
         tick();
      end
      checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL flush_last_lookup got=%b exp=0", lookup_hit); end
      lookup_valid = 1'b0;
      checks++; if (n != 8) begin failures++; $display("FAIL flush_len got=%0d exp=8", n); end
      checks++; if (upd_ready !== 1'b1) begin failures++; $display("FAIL flush_ready_after got=%b exp=1", upd_ready); end
      for (int i = 0; i < 8; i++) begin
         logic [9:0] pc;
         pc = 10'h200 | 10'(i << 4);
         do_lookup(pc);
         checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL post_flush_set%0d got=%b exp=0", i, lookup_hit); end
      end
      do_lookup(10'h300);
      checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL flush_upd_dropped got=%b exp=0", lookup_hit); end
   endtask

   task automatic test_stats();
      logic [31:0] exp_l, exp_h;
      do_flush();
      do_update(10'h0A4, 32'h0000_1000, 1'b1);
      do_update(10'h1A4, 32'h0000_2000, 1'b1);
      do_lookup(10'h0A4);
      do_lookup(10'h1A4);
      do_lookup(10'h2A4);
      do_lookup(10'h0A4);
      do_lookup(10'h3A4);
`ifdef BTB_STATS_EN
      exp_l = 32'd5; exp_h = 32'd3;
`else
      exp_l = 32'd0; exp_h = 32'd0;
`endif
      checks++; if (stat_lookups !== exp_l) begin failures++; $display("FAIL stat_lookups got=%0d exp=%0d", stat_lookups, exp_l); end
      checks++; if (stat_hits !== exp_h) begin failures++; $display("FAIL stat_hits got=%0d exp=%0d", stat_hits, exp_h); end
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      checks++; if (stat_lookups !== 32'd0 || stat_hits !== 32'd0) begin failures++; $display("FAIL stat_flush_clear got=%0d/%0d exp=0/0", stat_lookups, stat_hits); end
      for (int i = 0; i < 20 && flush_busy; i++) tick();
   endtask

   task automatic test_reset_mid_flush();
      do_update(10'h0A4, 32'h0000_7000, 1'b1);
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      tick();
      checks++; if (flush_busy !== 1'b1) begin failures++; $display("FAIL midflush_busy got=%b exp=1", flush_busy); end
      rst = 1'b1;
      #1;
      checks++; if (flush_busy !== 1'b0 || upd_ready !== 1'b1) begin failures++; $display("FAIL midflush_abort got=%b/%b exp=0/1", flush_busy, upd_ready); end
      tick();
      rst = 1'b0;
      do_lookup(10'h0A4);
      checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL midflush_cleared got=%b exp=0", lookup_hit); end
      do_update(10'h0A4, 32'h0000_8000, 1'b1);
      do_lookup(10'h0A4);
      checks++; if (lookup_hit !== 1'b1 || lookup_target !== 32'h0000_8000) begin failures++; $display("FAIL midflush_resume got=%b/%h exp=1/00008000", lookup_hit, lookup_target); end
   endtask

   initial begin
      test_reset();
      test_taken();
      test_lru();
      test_not_taken();
      test_back_to_back();
      test_flush();
      test_stats();
      test_reset_mid_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
